// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU clocking slice.
//   clk_state_t       : clock-controller FSM state (IDLE=0, RUN=1, STEP=2, HALT=3)
//   CLOCK_DIV_DEFAULT : system clocks per cpu_ce pulse in free-run
//   DEBOUNCE_DEFAULT  : stable samples needed before a debounced level changes
//   cnt_w()           : counter width able to hold 0..n-1 (minimum 1 bit)
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        CLK_IDLE = 2'd0,
        CLK_RUN  = 2'd1,
        CLK_STEP = 2'd2,
        CLK_HALT = 2'd3
    } clk_state_t;

    localparam int unsigned CLOCK_DIV_DEFAULT = 50_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT  = 1_000_000;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability-count debouncer for a raw,
// bouncy push-button. The debounced level flips only after DEBOUNCE_CYCLES
// consecutive synchronised samples that differ from the current level.
// A raw rise first seen in cycle N and held gives rise_pulse in cycle
// N+2+DEBOUNCE_CYCLES.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples required (>= 1)
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   din        in  raw button input (asynchronous)
//   level      out debounced level
//   rise_pulse out one-cycle pulse, coincident with level's rising edge
// ----------------------------------------------------------------------------
module btn_debounce
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          din_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    assign din_s = sync_q[1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (din_s != level_q) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = din_s;
                rise_d  = din_s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl
// Generates the single-cycle clock enable (cpu_ce) for every CPU register.
// Modes: free-run at clk/CLOCK_DIV, single-step from a debounced button,
// and sticky halt on the CPU HLT decode (left only through rst_n).
//
// Optional feature (macro CPU_CLK_CYCLE_COUNT_EN): adds the cycle_count
// output, a wrapping count of cpu_ce pulses cleared only by rst_n. Without
// the macro the port and the counter are absent and CNT_W is unused.
//
// Parameters:
//   CLOCK_DIV       : clocks per cpu_ce in RUN (>= 1; 1 = every cycle)
//   DEBOUNCE_CYCLES : step-button debounce length (>= 1)
//   CNT_W           : width of cycle_count
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   run_en      in  run/start switch (async level)
//   mode_step   in  0 = free-run, 1 = single-step (async level)
//   step_btn    in  raw step push-button (async, bouncy)
//   hlt_sw      in  manual pause switch (async level)
//   hlt_in      in  CPU HLT decode, already synchronous to clk
//   cpu_ce      out one-cycle clock enable to the CPU
//   phase       out toggles on every cpu_ce (LED slow clock)
//   state       out FSM state (IDLE=0, RUN=1, STEP=2, HALT=3)
//   halted      out high while state == HALT
//   cycle_count out cpu_ce pulse count (only with CPU_CLK_CYCLE_COUNT_EN)
// ----------------------------------------------------------------------------
module cpu_clk_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CLOCK_DIV       = CLOCK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             mode_step,
    input  logic             step_btn,
    input  logic             hlt_sw,
    input  logic             hlt_in,
    output logic             cpu_ce,
    output logic             phase,
    output logic [1:0]       state,
    output logic             halted
`ifdef CPU_CLK_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    if (CLOCK_DIV < 1 || DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("cpu_clk_ctrl: CLOCK_DIV, DEBOUNCE_CYCLES and CNT_W must be >= 1");
    end

    localparam int unsigned DW = cnt_w(CLOCK_DIV);

    // Synchronisers for the level inputs: bit 2 run_en, 1 mode_step, 0 hlt_sw.
    logic [2:0]    sync1_q, sync2_q;
    logic          run_en_s, mode_step_s, hlt_sw_s;

    logic          step_level, step_pulse;

    clk_state_t    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          ce_q, ce_d;
    logic          phase_q, phase_d;
    logic          halted_q, halted_d;

    assign run_en_s    = sync2_q[2];
    assign mode_step_s = sync2_q[1];
    assign hlt_sw_s    = sync2_q[0];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (step_btn),
        .level     (step_level),
        .rise_pulse(step_pulse)
    );

    assign tick = (div_q == DW'(CLOCK_DIV - 1));

    // Next-state logic, priority order as listed per state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLK_IDLE: begin
                if (run_en_s) state_d = mode_step_s ? CLK_STEP : CLK_RUN;
            end
            CLK_RUN: begin
                if (hlt_in)           state_d = CLK_HALT;
                else if (!run_en_s)   state_d = CLK_IDLE;
                else if (mode_step_s) state_d = CLK_STEP;
            end
            CLK_STEP: begin
                if (hlt_in)            state_d = CLK_HALT;
                else if (!run_en_s)    state_d = CLK_IDLE;
                else if (!mode_step_s) state_d = CLK_RUN;
            end
            CLK_HALT: state_d = CLK_HALT;
            default:  state_d = CLK_IDLE;
        endcase
    end

    // Divider only advances while staying in RUN; any other state (and hence
    // every fresh entry into RUN) starts it from zero. hlt_sw freezes it.
    always_comb begin
        div_d = '0;
        if (state_q == CLK_RUN && state_d == CLK_RUN) begin
            if (hlt_sw_s)  div_d = div_q;
            else if (tick) div_d = '0;
            else           div_d = div_q + DW'(1);
        end
    end

    // A step pulse that lands while mode_step has already dropped is
    // discarded rather than issued on the way back into RUN.
    always_comb begin
        ce_d = 1'b0;
        if (!hlt_sw_s && !hlt_in) begin
            if (state_q == CLK_RUN && tick)
                ce_d = 1'b1;
            if (state_q == CLK_STEP && step_pulse && step_level && mode_step_s)
                ce_d = 1'b1;
        end
        phase_d  = phase_q ^ ce_d;
        halted_d = (state_d == CLK_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= CLK_IDLE;
            div_q    <= '0;
            ce_q     <= 1'b0;
            phase_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            sync1_q  <= {run_en, mode_step, hlt_sw};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign cpu_ce = ce_q;
    assign phase  = phase_q;
    assign state  = state_q;
    assign halted = halted_q;

`ifdef CPU_CLK_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + CNT_W'(ce_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt_q <= '0;
        else        cyc_cnt_q <= cyc_cnt_d;
    end

    assign cycle_count = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

    localparam int unsigned DIV = 10;
    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_en = 1'b0, mode_step = 1'b0, step_btn = 1'b0;
    logic hlt_sw = 1'b0, hlt_in = 1'b0;
    logic cpu_ce, phase, halted;
    logic [1:0] state;
`ifdef CPU_CLK_CYCLE_COUNT_EN
    logic [CW-1:0] cycle_count;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(
        .CLOCK_DIV(DIV),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run_en(run_en),
        .mode_step(mode_step),
        .step_btn(step_btn),
        .hlt_sw(hlt_sw),
        .hlt_in(hlt_in),
        .cpu_ce(cpu_ce),
        .phase(phase),
        .state(state),
        .halted(halted)
`ifdef CPU_CLK_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    // ---------------- reference model (cycle-level, from the rules) ----------
    logic [1:0]    m_state;
    bit            m_ce, m_phase, m_halted, m_pulse, m_level;
    int            m_active;          // active RUN cycles since entering RUN
    logic [CW-1:0] m_cc;
    bit            run_p[2], mode_p[2], hsw_p[2];
    bit            btn_h[DEB+1];      // btn_h[k] = raw button captured k+1 edges ago

    task automatic model_reset();
        m_state = 2'd0; m_ce = 0; m_phase = 0; m_halted = 0; m_pulse = 0;
        m_level = 0; m_active = 0; m_cc = '0;
        run_p = '{0, 0}; mode_p = '{0, 0}; hsw_p = '{0, 0};
        for (int i = 0; i <= DEB; i++) btn_h[i] = 0;
    endtask

    task automatic model_update();
        bit run_s, mode_s, hsw_s, tick, ce_n, pulse_n, stable, smp;
        logic [1:0] ns;
        run_s  = run_p[1];
        mode_s = mode_p[1];
        hsw_s  = hsw_p[1];
        tick   = (m_state == 2'd1) && ((m_active % DIV) == DIV - 1);
        ce_n   = (tick || (m_state == 2'd2 && m_pulse && mode_s)) && !hsw_s && !hlt_in;
        // debounced level flips once the last DEB synced samples all disagree
        smp = btn_h[1];
        stable = 1;
        for (int i = 1; i <= DEB; i++) if (btn_h[i] != smp) stable = 0;
        pulse_n = 0;
        if (stable && smp != m_level) begin
            m_level = smp;
            pulse_n = smp;
        end
        ns = m_state;
        case (m_state)
            2'd0: if (run_s) ns = mode_s ? 2'd2 : 2'd1;
            2'd1: if (hlt_in) ns = 2'd3; else if (!run_s) ns = 2'd0; else if (mode_s) ns = 2'd2;
            2'd2: if (hlt_in) ns = 2'd3; else if (!run_s) ns = 2'd0; else if (!mode_s) ns = 2'd1;
            default: ns = 2'd3;
        endcase
        if (m_state == 2'd1 && ns == 2'd1) begin
            if (!hsw_s) m_active++;
        end else begin
            m_active = 0;
        end
        m_ce = ce_n;
        m_phase = m_phase ^ ce_n;
        m_cc = m_cc + CW'(ce_n);
        m_halted = (ns == 2'd3);
        m_state = ns;
        m_pulse = pulse_n;
        run_p[1] = run_p[0];   run_p[0] = run_en;
        mode_p[1] = mode_p[0]; mode_p[0] = mode_step;
        hsw_p[1] = hsw_p[0];   hsw_p[0] = hlt_sw;
        for (int i = DEB; i >= 1; i--) btn_h[i] = btn_h[i-1];
        btn_h[0] = step_btn;
    endtask

    // Advance one clock: model steps on the edge, outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        run_en = 0; mode_step = 0; step_btn = 0; hlt_sw = 0; hlt_in = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        apply_reset();
        vectors++;
        if ({cpu_ce, phase, halted, state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", {cpu_ce, phase, halted, state}, 5'b0);
        end
    endtask

    task automatic test_run_rate();
        int first_run = -1, last_ce = -1, pulses = 0;
        bit prev_ce = 0;
        run_en = 1; mode_step = 0;
        for (int c = 1; c <= 70; c++) begin
            cyc();
            vectors++;
            if ({cpu_ce, phase, halted, state} !== {m_ce, m_phase, m_halted, m_state}) begin
                errors++;
                $display("FAIL run_model: cycle %0d got %b required %b", c,
                         {cpu_ce, phase, halted, state}, {m_ce, m_phase, m_halted, m_state});
            end
            if (state == 2'd1 && first_run < 0) first_run = c;
            if (cpu_ce) begin
                vectors++;
                if (prev_ce !== 1'b0) begin
                    errors++;
                    $display("FAIL run_ce_width: cycle %0d previous ce %b required 0", c, prev_ce);
                end
                if (last_ce >= 0) begin
                    vectors++;
                    if (c - last_ce != int'(DIV)) begin
                        errors++;
                        $display("FAIL run_interval: got %0d required %0d", c - last_ce, DIV);
                    end
                end
                last_ce = c;
                pulses++;
                if (pulses == 5) begin
                    vectors++;
                    if (phase !== 1'b1) begin
                        errors++;
                        $display("FAIL run_phase5: got %b required 1", phase);
                    end
`ifdef CPU_CLK_CYCLE_COUNT_EN
                    vectors++;
                    if (cycle_count !== CW'(5)) begin
                        errors++;
                        $display("FAIL run_count5: got %0d required 5", cycle_count);
                    end
`endif
                end
            end
            prev_ce = cpu_ce;
        end
        vectors++;
        if (first_run != 3) begin
            errors++;
            $display("FAIL run_entry: RUN seen at cycle %0d required 3", first_run);
        end
        vectors++;
        if (last_ce != 3 + int'(DIV)) begin
            if (pulses == 0 || (last_ce - 3) % int'(DIV) != 0) begin
                errors++;
                $display("FAIL run_first_ce: last ce at %0d not aligned to RUN+%0d*k", last_ce, DIV);
            end
        end
    endtask

    task automatic test_halt_on_tick();
        for (int k = 0; k < 25 && !(m_state == 2'd1 && (m_active % DIV) == DIV - 1); k++) cyc();
        vectors++;
        if (!(m_state == 2'd1 && (m_active % DIV) == DIV - 1)) begin
            errors++;
            $display("FAIL halt_wait: tick cycle not reached, state %0d", state);
        end
        hlt_in = 1;
        cyc();
        hlt_in = 0;
        vectors++;
        if ({cpu_ce, halted, state} !== {1'b0, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL halt_entry: ce/halted/state got %b required %b",
                     {cpu_ce, halted, state}, {1'b0, 1'b1, 2'd3});
        end
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) run_en = ~run_en;
            cyc();
            vectors++;
            if ({cpu_ce, halted, state} !== {1'b0, 1'b1, 2'd3}) begin
                errors++;
                $display("FAIL halt_sticky: cycle %0d got %b required %b", k,
                         {cpu_ce, halted, state}, {1'b0, 1'b1, 2'd3});
            end
        end
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if ({cpu_ce, phase, halted, state} !== 5'b0) begin
            errors++;
            $display("FAIL halt_reset: got %b required %b", {cpu_ce, phase, halted, state}, 5'b0);
        end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_step_bouncy();
        int ce_at, nce;
        apply_reset();
        run_en = 1; mode_step = 1;
        repeat (4) cyc();
        vectors++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL step_entry: state got %0d required 2", state);
        end
        for (int i = 0; i < 6; i++) begin
            step_btn = (i % 2 == 0);
            cyc();
            vectors++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL step_bounce: cycle %0d ce got %b required 0", i, cpu_ce);
            end
        end
        for (int press = 0; press < 2; press++) begin
            step_btn = 1;
            ce_at = -1; nce = 0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                vectors++;
                if ({cpu_ce, phase, state} !== {m_ce, m_phase, m_state}) begin
                    errors++;
                    $display("FAIL step_model: press %0d cycle %0d got %b required %b", press, k,
                             {cpu_ce, phase, state}, {m_ce, m_phase, m_state});
                end
                if (cpu_ce) begin
                    nce++;
                    if (ce_at < 0) ce_at = k;
                end
            end
            vectors++;
            if (ce_at != 7 || nce != 1) begin
                errors++;
                $display("FAIL step_pulse: press %0d first ce at N+%0d count %0d required N+7 count 1",
                         press, ce_at, nce);
            end
            step_btn = 0;
            nce = 0;
            for (int k = 0; k < 12; k++) begin
                cyc();
                if (cpu_ce) nce++;
            end
            vectors++;
            if (nce != 0) begin
                errors++;
                $display("FAIL step_release: got %0d ce pulses required 0", nce);
            end
        end
    endtask

    task automatic test_pause();
        int nce, ce_at;
        apply_reset();
        run_en = 1; mode_step = 0;
        for (int k = 0; k < 40 && !(m_state == 2'd1 && m_active == 4); k++) cyc();
        vectors++;
        if (!(m_state == 2'd1 && m_active == 4)) begin
            errors++;
            $display("FAIL pause_wait: count 4 in RUN not reached, state %0d", state);
        end
        hlt_sw = 1;
        nce = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (cpu_ce) nce++;
        end
        vectors++;
        if (nce != 0) begin
            errors++;
            $display("FAIL pause_no_ce: got %0d pulses required 0", nce);
        end
        hlt_sw = 0;
        ce_at = -1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            vectors++;
            if ({cpu_ce, phase, state} !== {m_ce, m_phase, m_state}) begin
                errors++;
                $display("FAIL pause_model: cycle %0d got %b required %b", k,
                         {cpu_ce, phase, state}, {m_ce, m_phase, m_state});
            end
            if (cpu_ce && ce_at < 0) ce_at = k;
        end
        vectors++;
        if (ce_at != 6) begin
            errors++;
            $display("FAIL pause_resume: ce after release at %0d required 6", ce_at);
        end
    endtask

    task automatic test_run_drop();
        int idle_at = -1, ce_at = -1;
        for (int k = 0; k < 30 && !(m_state == 2'd1 && (m_active % DIV) == 5); k++) cyc();
        run_en = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (state == 2'd0 && idle_at < 0) idle_at = k;
        end
        vectors++;
        if (idle_at != 3) begin
            errors++;
            $display("FAIL drop_idle: IDLE at %0d required 3", idle_at);
        end
        run_en = 1;
        for (int k = 0; k < 10 && state != 2'd1; k++) cyc();
        vectors++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL drop_reentry: state got %0d required 1", state);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (cpu_ce && ce_at < 0) ce_at = k;
        end
        vectors++;
        if (ce_at != int'(DIV)) begin
            errors++;
            $display("FAIL drop_first_ce: got %0d cycles required %0d", ce_at, DIV);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            if ($urandom_range(0, 29) == 0) mode_step = ~mode_step;
            if ($urandom_range(0, 24) == 0) hlt_sw = ~hlt_sw;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            hlt_in = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            cyc();
            vectors++;
            if ({cpu_ce, phase, halted, state} !== {m_ce, m_phase, m_halted, m_state}) begin
                errors++;
                $display("FAIL random_model: cycle %0d got %b required %b", c,
                         {cpu_ce, phase, halted, state}, {m_ce, m_phase, m_halted, m_state});
            end
`ifdef CPU_CLK_CYCLE_COUNT_EN
            vectors++;
            if (cycle_count !== m_cc) begin
                errors++;
                $display("FAIL random_count: cycle %0d got %0d required %0d", c, cycle_count, m_cc);
            end
`endif
        end
        rst_n = 1;
        hlt_in = 0;
    endtask

`ifdef CPU_CLK_CYCLE_COUNT_EN
    task automatic test_wrap();
        int pulses = 0;
        apply_reset();
        run_en = 1; mode_step = 0;
        for (int k = 0; k < 3000 && pulses < 256; k++) begin
            cyc();
            if (cpu_ce) pulses++;
        end
        vectors++;
        if (pulses != 256 || cycle_count !== CW'(0)) begin
            errors++;
            $display("FAIL count_wrap: pulses %0d cycle_count %0d required 256 and 0", pulses, cycle_count);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_run_rate();
        test_halt_on_tick();
        test_step_bouncy();
        test_pause();
        test_run_drop();
        test_random();
`ifdef CPU_CLK_CYCLE_COUNT_EN
        test_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Parametrised successor to the fixed clock divider and start/halt switch handling inside the CPU top.
- Generates a one-cycle clock-enable pulse (cpu_ce) for all CPU registers.
- Supports three modes: free-run at a divided rate, single-step from a debounced push-button, and halt on the CPU HLT instruction.
- Sits between the board switches/buttons and the CPU core; the whole CPU stays on the single system clock.

Parameters:
- CLOCK_DIV, 50_000_000: system clocks per cpu_ce pulse in RUN. Must be ≥1; 1 gives a ce every cycle.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required before the debounced step level changes. Must be ≥1.
- CNT_W, 16: width of cycle_count.

Ports:
- clk  in  1  system clock (100 MHz board clock)
- rst_n  in  1  reset; asynchronous assert, active-low
- run_en  in  1  run/start switch, asynchronous level
- mode_step  in  1  0 = free-run, 1 = single-step; asynchronous level
- step_btn  in  1  raw step push-button, asynchronous, bouncy
- hlt_sw  in  1  manual pause switch, asynchronous level
- hlt_in  in  1  CPU HLT decode, synchronous to clk
- cpu_ce  out  1  single-cycle clock-enable to the CPU
- phase  out  1  toggles on every cpu_ce; drives the LED "slow clock"
- state  out  2  FSM state: IDLE=0, RUN=1, STEP=2, HALT=3
- halted  out  1  high while state == HALT
- cycle_count  out  CNT_W  number of cpu_ce pulses issued (present only under the optional feature)

Behaviour:
- Reset (rst_n=0): state=IDLE; cpu_ce=0, phase=0, halted=0, cycle_count=0. Divider, synchronisers and debouncer cleared. Reset applied mid-RUN or mid-STEP aborts immediately.
- Synchronisers: run_en, mode_step, hlt_sw and step_btn each pass through 2 flops (suffix _s). hlt_in is used unsynchronised.
- Divider:
  - Counts 0..CLOCK_DIV-1 only in RUN with hlt_sw_s=0.
  - tick when count == CLOCK_DIV-1; count then wraps to 0.
  - Frozen (held, not cleared) while hlt_sw_s=1.
  - Cleared to 0 on every entry to RUN and in all other states.
- Debouncer:
  - Debounced level takes the new value after DEBOUNCE_CYCLES consecutive cycles of a stable synchronised sample differing from the current level.
  - step_pulse = one cycle on the debounced rising edge.
  - Raw rise first seen in cycle N and held ⇒ step_pulse in cycle N+2+DEBOUNCE_CYCLES.
- FSM transitions, evaluated each clk in priority order:
  - IDLE: run_en_s=1 & mode_step_s=0 → RUN. run_en_s=1 & mode_step_s=1 → STEP.
  - RUN: hlt_in=1 → HALT. Else run_en_s=0 → IDLE. Else mode_step_s=1 → STEP.
  - STEP: hlt_in=1 → HALT. Else run_en_s=0 → IDLE. Else mode_step_s=0 → RUN.
  - HALT: sticky; exits only through rst_n.
- cpu_ce generation:
  - Registered; asserted the cycle after the qualifying event.
  - Qualifying events: RUN & tick & hlt_sw_s=0 & hlt_in=0, or STEP & step_pulse & hlt_sw_s=0 & hlt_in=0.
  - Never asserted in IDLE or HALT.
  - Always exactly one cycle wide; never back-to-back unless CLOCK_DIV=1.
- Simultaneous events:
  - tick with hlt_in=1: ce suppressed, go to HALT.
  - step_pulse while hlt_sw_s=1: pulse dropped, not queued.
  - step_pulse in the same cycle as mode_step_s falling: pulse dropped, go to RUN.
- phase toggles on each cycle cpu_ce=1.
- halted is registered and equals (state==HALT).

Optional Feature:
- Macro CPU_CLK_CYCLE_COUNT_EN.
- Defined: cycle_count port exists. It increments by 1 in each cycle cpu_ce=1, wraps 2^CNT_W-1 → 0, and is cleared only by rst_n.
- Undefined: port and counter are absent; CNT_W is unused.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings CLK_IDLE/CLK_RUN/CLK_STEP/CLK_HALT (2-bit typedef clk_state_t)
  - default constants CLOCK_DIV_DEFAULT and DEBOUNCE_DEFAULT
- Natural sub-module: btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst_n, din, level, rise_pulse), with 2-flop sync included. Reused later for other buttons.
- Divider and FSM stay in cpu_clk_ctrl.

Test Plan (CLOCK_DIV=10, DEBOUNCE_CYCLES=4, CNT_W=8):
- Reset, then run_en=1, mode_step=0: state=RUN 3 cycles after run_en rises. cpu_ce pulses every 10 cycles, each 1 cycle wide. After 5 pulses phase=1 and cycle_count=5.
- Free-run, assert hlt_in for 1 cycle coincident with tick: no cpu_ce, state=HALT, halted=1. Stays HALT with run_en toggled; rst_n low returns state=IDLE, all outputs 0.
- mode_step=1, bouncy step_btn (toggle every cycle for 6 cycles, then held high at cycle N): exactly one cpu_ce, at cycle N+7. Holding high produces no further pulse; release and re-press gives a second pulse.
- RUN with hlt_sw=1 for 25 cycles mid-count (count=6): no cpu_ce during the pause. After release the next cpu_ce arrives 3+3 cycles later; the divider resumes from 6.
- run_en dropped mid-RUN at count=7, then re-raised: state=IDLE, count cleared. First cpu_ce comes a full 10 cycles after RUN re-entry.
- cycle_count wrap: 256 pulses → cycle_count=0. With the macro undefined, the design elaborates without the port.
